// File: rtl/bcd_entry_to_bin_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry_to_bin_if
//  Description : Keypad-side strobes and ALU-side valid/ready operand port
//                of the decimal entry block. The master is the keypad
//                front end plus the operand consumer. The slave is the
//                entry block itself.
//                Optional del_i exists only with BCD_ENTRY_BACKSPACE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_entry_to_bin_if;
    logic [1:0]  op_i;
    logic [3:0]  digit_i;
    logic        digit_valid_i;
    logic        neg_i;
    logic        commit_i;
    logic        clear_i;
`ifdef BCD_ENTRY_BACKSPACE_EN
    logic        del_i;
`endif
    logic [11:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        err_o;
    logic [2:0]  count_o;

    modport master (
        output op_i, digit_i, digit_valid_i, neg_i, commit_i, clear_i,
               data_ready_i,
`ifdef BCD_ENTRY_BACKSPACE_EN
        output del_i,
`endif
        input  data_o, data_valid_o, err_o, count_o
    );

    modport slave (
        input  op_i, digit_i, digit_valid_i, neg_i, commit_i, clear_i,
               data_ready_i,
`ifdef BCD_ENTRY_BACKSPACE_EN
        input  del_i,
`endif
        output data_o, data_valid_o, err_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/bcd_entry_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_entry_to_bin
//  Description : Collects up to four BCD digits with a sign flag. On commit
//                it converts them to binary with a 4-clock MSD-first x10
//                accumulate. It then range-checks the result for the latched
//                op mode and offers the 12-bit operand on a valid/ready port.
//                Optional backspace key: define BCD_ENTRY_BACKSPACE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_entry_to_bin #(
    parameter int DIGITS = 4,
    parameter int W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_entry_to_bin_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_CONV  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [2:0]  c_MAX_COUNT  = 3'(DIGITS);
    localparam logic [13:0] c_POS_LIM_6  = 14'd31;
    localparam logic [13:0] c_NEG_LIM_6  = 14'd32;
    localparam logic [13:0] c_POS_LIM_12 = 14'd2047;
    localparam logic [13:0] c_NEG_LIM_12 = 14'd2048;
    localparam logic [6:0]  c_FIELD_LIM  = 7'd63;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DIGITS-1:0][3:0]   r_buf;      // r_buf[0] is the least significant digit
    logic [2:0]               r_count;
    logic                     r_sign;
    logic [1:0]               r_op;
    logic [13:0]              r_acc;      // whole 4-digit value
    logic [6:0]               r_acc_hi;   // digits [3:2] only, for split mode
    logic [6:0]               r_acc_lo;   // digits [1:0] only, for split mode
    logic [1:0]               r_step;
    logic [W-1:0]             r_data;
    logic                     r_valid;
    logic                     r_err;

    logic        w_del_req;
    logic        w_do_clear;
    logic        w_do_commit;
    logic        w_do_del;
    logic        w_do_digit;
    logic        w_do_neg;
    logic        w_do_step;
    logic        w_do_finish;
    logic        w_do_release;
    logic [1:0]  w_idx;
    logic [3:0]  w_digit_cur;
    logic [13:0] w_acc_next;
    logic [6:0]  w_hi_next;
    logic [6:0]  w_lo_next;
    logic [11:0] w_signed12;
    logic        w_range_ok;
    logic [W-1:0] w_result;

`ifdef BCD_ENTRY_BACKSPACE_EN
    assign w_del_req = bus.del_i;
`else
    assign w_del_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and one-hot action strobes; clear beats every other key
    always_comb begin
        w_state_next = r_state;
        w_do_clear   = 1'b0;
        w_do_commit  = 1'b0;
        w_do_del     = 1'b0;
        w_do_digit   = 1'b0;
        w_do_neg     = 1'b0;
        w_do_step    = 1'b0;
        w_do_finish  = 1'b0;
        w_do_release = 1'b0;
        if (bus.clear_i) begin
            w_do_clear   = 1'b1;
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (bus.commit_i) begin
                        w_do_commit  = 1'b1;
                        w_state_next = S_CONV;
                    end else if (w_del_req) begin
                        w_do_del = 1'b1;
                        if (r_count <= 3'd1) begin
                            w_state_next = S_IDLE;
                        end
                    end else if (bus.digit_valid_i) begin
                        // Non-decimal codes and a fifth digit are dropped
                        if ((bus.digit_i <= 4'd9) && (r_count < c_MAX_COUNT)) begin
                            w_do_digit   = 1'b1;
                            w_state_next = S_ENTRY;
                        end
                    end else if (bus.neg_i) begin
                        w_do_neg = 1'b1;
                    end
                end
                S_CONV: begin
                    w_do_step = 1'b1;
                    if (r_step == 2'd3) begin
                        w_do_finish  = 1'b1;
                        w_state_next = w_range_ok ? S_HOLD : S_ERR;
                    end
                end
                S_HOLD: begin
                    if (bus.data_ready_i) begin
                        w_do_release = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_ERR: begin
                    w_state_next = S_ERR;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // One x10 accumulate step per CONV clock, walking MSD to LSD
    always_comb begin
        w_idx       = 2'd3 - r_step;
        w_digit_cur = r_buf[w_idx];
        w_acc_next  = (r_acc << 3) + (r_acc << 1) + 14'(w_digit_cur);
        w_hi_next   = r_acc_hi;
        w_lo_next   = r_acc_lo;
        if (r_step < 2'd2) begin
            w_hi_next = (r_acc_hi << 3) + (r_acc_hi << 1) + 7'(w_digit_cur);
        end else begin
            w_lo_next = (r_acc_lo << 3) + (r_acc_lo << 1) + 7'(w_digit_cur);
        end
    end

    // Range check and output formatting on the final CONV clock; uses the
    // value being accumulated that same clock so no extra cycle is needed
    always_comb begin
        w_signed12 = r_sign ? (12'd0 - w_acc_next[11:0]) : w_acc_next[11:0];
        w_range_ok = 1'b0;
        w_result   = '0;
        case (r_op)
            2'b10: begin
                w_range_ok = r_sign ? (w_acc_next <= c_NEG_LIM_12)
                                    : (w_acc_next <= c_POS_LIM_12);
                w_result   = w_signed12;
            end
            2'b11: begin
                // Sign is meaningless for the two unsigned fields
                w_range_ok = (r_acc_hi <= c_FIELD_LIM) && (w_lo_next <= c_FIELD_LIM);
                w_result   = {r_acc_hi[5:0], w_lo_next[5:0]};
            end
            default: begin
                w_range_ok = (r_count <= 3'd2) &&
                             (r_sign ? (w_acc_next <= c_NEG_LIM_6)
                                     : (w_acc_next <= c_POS_LIM_6));
                w_result   = {6'd0, w_signed12[5:0]};
            end
        endcase
    end

    // Digit buffer, sign, accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf    <= '0;
            r_count  <= 3'd0;
            r_sign   <= 1'b0;
            r_op     <= 2'b00;
            r_acc    <= 14'd0;
            r_acc_hi <= 7'd0;
            r_acc_lo <= 7'd0;
            r_step   <= 2'd0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_do_clear) begin
            r_buf    <= '0;
            r_count  <= 3'd0;
            r_sign   <= 1'b0;
            r_op     <= 2'b00;
            r_acc    <= 14'd0;
            r_acc_hi <= 7'd0;
            r_acc_lo <= 7'd0;
            r_step   <= 2'd0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_do_digit) begin
                r_buf   <= {r_buf[DIGITS-2:0], bus.digit_i};
                r_count <= r_count + 3'd1;
            end
            if (w_do_del) begin
                r_buf <= {4'd0, r_buf[DIGITS-1:1]};
                if (r_count != 3'd0) begin
                    r_count <= r_count - 3'd1;
                end
            end
            if (w_do_neg) begin
                r_sign <= ~r_sign;
            end
            if (w_do_commit) begin
                r_op     <= bus.op_i;
                r_acc    <= 14'd0;
                r_acc_hi <= 7'd0;
                r_acc_lo <= 7'd0;
                r_step   <= 2'd0;
            end
            if (w_do_step) begin
                r_acc    <= w_acc_next;
                r_acc_hi <= w_hi_next;
                r_acc_lo <= w_lo_next;
                r_step   <= r_step + 2'd1;
            end
            if (w_do_finish) begin
                if (w_range_ok) begin
                    r_data  <= w_result;
                    r_valid <= 1'b1;
                end else begin
                    r_data  <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (w_do_release) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_buf   <= '0;
                r_sign  <= 1'b0;
                r_count <= 3'd0;
            end
        end
    end

    assign bus.data_o       = r_data;
    assign bus.data_valid_o = r_valid;
    assign bus.err_o        = r_err;
    assign bus.count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_entry_to_bin
//  Description : Self-checking bench for bcd_entry_to_bin. A vector table plus
//                hand-written corner sequences; expected results are queued at
//                commit and popped when the block answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_entry_to_bin;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_entry_to_bin_if bus ();

    bcd_entry_to_bin #(.DIGITS(4), .W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        int          nneg;
        int          ndig;
        logic [15:0] dig;       // digits as nibbles, entered most significant first
        logic [11:0] exp_data;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [11:0] data;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [1:0] op, input int nneg, input int ndig,
                                input logic [15:0] dig, input logic [11:0] d, input bit e);
        vec_t v;
        v.op = op; v.nneg = nneg; v.ndig = ndig; v.dig = dig; v.exp_data = d; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        bus.digit_i = d; bus.digit_valid_i = 1'b1; tick(); bus.digit_valid_i = 1'b0;
    endtask
    task automatic press_neg();
        bus.neg_i = 1'b1; tick(); bus.neg_i = 1'b0;
    endtask
    task automatic press_clear();
        bus.clear_i = 1'b1; tick(); bus.clear_i = 1'b0;
    endtask
    task automatic press_ready();
        bus.data_ready_i = 1'b1; tick(); bus.data_ready_i = 1'b0;
    endtask

    // Commits, then checks latency and the scoreboard head; leaves DUT in HOLD/ERR
    task automatic commit_and_check(input string name, input logic [1:0] op,
                                    input logic [11:0] ed, input bit ee);
        exp_t e;
        int   lat;
        bit   seen;
        e.data = ed; e.err = ee;
        sb.push_back(e);
        bus.op_i = op;
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        bus.op_i = 2'b00;
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.data_valid_o || bus.err_o) begin
                seen = 1'b1; lat = i; break;
            end
        end
        check({name, " seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check({name, " latency"}, lat, 4);
            check({name, " data"},  32'(bus.data_o), 32'(e.data));
            check({name, " err"},   32'(bus.err_o), 32'(e.err));
            check({name, " valid"}, 32'(bus.data_valid_o), 32'(!e.err));
        end
    endtask

    task automatic expect_silence(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.data_valid_o || bus.err_o) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_i = 2'b00; bus.digit_i = 4'd0; bus.digit_valid_i = 1'b0;
        bus.neg_i = 1'b0; bus.commit_i = 1'b0; bus.clear_i = 1'b0;
        bus.data_ready_i = 1'b0;
`ifdef BCD_ENTRY_BACKSPACE_EN
        bus.del_i = 1'b0;
`endif
        vecs.push_back(mk(2'b10, 0, 4, 16'h1234, 12'h4D2, 0));
        vecs.push_back(mk(2'b10, 1, 4, 16'h2048, 12'h800, 0));
        vecs.push_back(mk(2'b10, 0, 4, 16'h2048, 12'h000, 1));
        vecs.push_back(mk(2'b10, 0, 4, 16'h2047, 12'h7FF, 0));
        vecs.push_back(mk(2'b10, 1, 4, 16'h2049, 12'h000, 1));
        vecs.push_back(mk(2'b10, 1, 3, 16'h0999, 12'hC19, 0));
        vecs.push_back(mk(2'b10, 1, 1, 16'h0000, 12'h000, 0));
        vecs.push_back(mk(2'b10, 0, 0, 16'h0000, 12'h000, 0));
        vecs.push_back(mk(2'b10, 0, 4, 16'h9999, 12'h000, 1));
        vecs.push_back(mk(2'b11, 0, 4, 16'h6307, 12'hFC7, 0));
        vecs.push_back(mk(2'b11, 0, 4, 16'h6400, 12'h000, 1));
        vecs.push_back(mk(2'b11, 0, 4, 16'h9963, 12'h000, 1));
        vecs.push_back(mk(2'b11, 1, 4, 16'h0512, 12'h14C, 0));
        vecs.push_back(mk(2'b11, 0, 2, 16'h0045, 12'h02D, 0));
        vecs.push_back(mk(2'b00, 1, 2, 16'h0032, 12'h020, 0));
        vecs.push_back(mk(2'b00, 1, 2, 16'h0033, 12'h000, 1));
        vecs.push_back(mk(2'b00, 0, 3, 16'h0123, 12'h000, 1));
        vecs.push_back(mk(2'b01, 0, 2, 16'h0031, 12'h01F, 0));
        vecs.push_back(mk(2'b01, 0, 2, 16'h0032, 12'h000, 1));
        vecs.push_back(mk(2'b00, 1, 1, 16'h0005, 12'h03B, 0));
        vecs.push_back(mk(2'b00, 2, 1, 16'h0005, 12'h005, 0));

        // Reset values, both while held and after release
        #12;
        check("reset valid", 32'(bus.data_valid_o), 32'd0);
        check("reset err",   32'(bus.err_o), 32'd0);
        check("reset data",  32'(bus.data_o), 32'd0);
        check("reset count", 32'(bus.count_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset count", 32'(bus.count_o), 32'd0);

        // Vector table
        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            press_clear();
            check({nm, " cleared err"}, 32'(bus.err_o), 32'd0);
            for (int n = 0; n < vecs[k].nneg; n++) press_neg();
            for (int i = vecs[k].ndig - 1; i >= 0; i--) press_digit(vecs[k].dig[i*4 +: 4]);
            check({nm, " count"}, 32'(bus.count_o), 32'(vecs[k].ndig));
            commit_and_check(nm, vecs[k].op, vecs[k].exp_data, vecs[k].exp_err);
            if (bus.data_valid_o) begin
                press_ready();
                check({nm, " released valid"}, 32'(bus.data_valid_o), 32'd0);
                check({nm, " released count"}, 32'(bus.count_o), 32'd0);
            end
        end

        // HOLD keeps data stable and ignores keys until ready
        press_clear();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        commit_and_check("hold", 2'b10, 12'h4D2, 0);
        for (int i = 0; i < 3; i++) begin
            bus.digit_i = 4'd5; bus.digit_valid_i = 1'b1; bus.neg_i = 1'b1; bus.commit_i = 1'b1;
            tick();
            bus.digit_valid_i = 1'b0; bus.neg_i = 1'b0; bus.commit_i = 1'b0;
            check("hold data",  32'(bus.data_o), 32'h4D2);
            check("hold valid", 32'(bus.data_valid_o), 32'd1);
            check("hold count", 32'(bus.count_o), 32'd4);
        end
        press_ready();
        check("hold release valid", 32'(bus.data_valid_o), 32'd0);
        check("hold release count", 32'(bus.count_o), 32'd0);

        // ERR is sticky against every key except clear
        press_digit(4'd2); press_digit(4'd0); press_digit(4'd4); press_digit(4'd8);
        commit_and_check("err", 2'b10, 12'h000, 1);
        press_digit(4'd1); press_neg(); press_ready();
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        tick(); tick(); tick(); tick();
        check("err sticky", 32'(bus.err_o), 32'd1);
        check("err valid",  32'(bus.data_valid_o), 32'd0);
        check("err data",   32'(bus.data_o), 32'd0);
        press_clear();
        check("err cleared", 32'(bus.err_o), 32'd0);
        check("err cleared count", 32'(bus.count_o), 32'd0);

        // Non-decimal code and fifth digit are ignored; ready outside HOLD is inert
        press_digit(4'd1);
        press_digit(4'hA);
        check("digit A ignored", 32'(bus.count_o), 32'd1);
        bus.data_ready_i = 1'b1;
        press_digit(4'd2);
        bus.data_ready_i = 1'b0;
        press_digit(4'd3); press_digit(4'd4); press_digit(4'd5);
        check("fifth digit ignored", 32'(bus.count_o), 32'd4);
        commit_and_check("five digits", 2'b10, 12'h4D2, 0);
        press_ready();

        // Clear on the second CONV clock aborts the conversion
        press_digit(4'd1); press_digit(4'd2);
        bus.op_i = 2'b10; bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        tick();
        press_clear();
        check("abort valid", 32'(bus.data_valid_o), 32'd0);
        check("abort err",   32'(bus.err_o), 32'd0);
        check("abort count", 32'(bus.count_o), 32'd0);
        expect_silence("abort no result");

        // Clear and commit in the same cycle: clear wins, nothing converts
        press_digit(4'd5);
        bus.clear_i = 1'b1; bus.commit_i = 1'b1; tick();
        bus.clear_i = 1'b0; bus.commit_i = 1'b0;
        check("clear+commit count", 32'(bus.count_o), 32'd0);
        expect_silence("clear+commit no result");

        // Asynchronous reset while holding a result
        press_digit(4'd7);
        commit_and_check("pre-reset", 2'b10, 12'h007, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid", 32'(bus.data_valid_o), 32'd0);
        check("async reset data",  32'(bus.data_o), 32'd0);
        check("async reset count", 32'(bus.count_o), 32'd0);
        #1 rst_n = 1'b1;
        press_digit(4'd9);
        check("after reset entry", 32'(bus.count_o), 32'd1);
        commit_and_check("after reset", 2'b10, 12'h009, 0);
        press_ready();

`ifdef BCD_ENTRY_BACKSPACE_EN
        // Backspace drops the last digit; counts step 1,2,3,2,3
        press_digit(4'd1); check("bs count1", 32'(bus.count_o), 32'd1);
        press_digit(4'd2); check("bs count2", 32'(bus.count_o), 32'd2);
        press_digit(4'd3); check("bs count3", 32'(bus.count_o), 32'd3);
        bus.del_i = 1'b1; tick(); bus.del_i = 1'b0;
        check("bs count del", 32'(bus.count_o), 32'd2);
        press_digit(4'd9); check("bs count4", 32'(bus.count_o), 32'd3);
        commit_and_check("backspace", 2'b10, 12'h081, 0);
        press_ready();
        press_digit(4'd4);
        for (int i = 0; i < 3; i++) begin
            bus.del_i = 1'b1; tick(); bus.del_i = 1'b0;
        end
        check("bs saturate", 32'(bus.count_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
